rs232_programmer: RTL and testbench

Serial-download engine that turns a byte stream from the UART receive buffer into 32-bit memory writes. Bytes are pulled from an 8-entry circular RX buffer owned by the UART, and each byte is echoed back through the UART TX path. Every four bytes are assembled MSB-first into a word and written to program memory at an auto-incrementing word address. The block sits between the RS232 UART core and the target memory write port.

---
 rtl/rs232_pkg.sv | 15 +
 rtl/rs232_word_assembler.sv | 28 ++
 rtl/rs232_programmer.sv | 90 +++++++++
 tb/tb_rs232_programmer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 serial-download engine.
package rs232_pkg;

  localparam int RX_PTR_W       = 3;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ECHO  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/rs232_word_assembler.sv
// Packs echoed bytes MSB-first into a word and tracks position within the word.
module rs232_word_assembler
  import rs232_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  cnt,
  output logic              word_ready
);

  // High while the next shift delivers the final byte of the word.
  assign word_ready = (cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= {word[WORD_W-9:0], byte_in};
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rs232_programmer.sv
// Drains the UART RX buffer, echoes each byte to TX, and writes every four
// bytes as one 32-bit word to program memory at an auto-incrementing address.
module rs232_programmer
  import rs232_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [7:0]          oInfobyte,
  output logic [WORD_W-1:0]   dout,
  output logic [WORD_W-1:0]   addr_out,
  output logic                we,
  output logic [7:0]          iData_RS232,
  output logic                WriteEnable_RS232,
  input  logic                oWrBuffer_full_RS232,
  input  logic [7:0]          oData_RS232,
  output logic [RX_PTR_W-1:0] read_addr_RS232,
  input  logic [RX_PTR_W-1:0] rx_addr_RS232
);

  state_e              state;
  logic [7:0]          byte_r;
  logic [WORD_W-1:0]   word;
  logic [CNT_W-1:0]    cnt;
  logic                word_ready;
  logic                shift_en;
  logic                rx_avail;

  assign rx_avail = (read_addr_RS232 != rx_addr_RS232);
  assign shift_en = enable && (state == ECHO) && !oWrBuffer_full_RS232;

  rs232_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (!enable),
    .shift_en   (shift_en),
    .byte_in    (byte_r),
    .word       (word),
    .cnt        (cnt),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      byte_r            <= '0;
      oInfobyte         <= '0;
      dout              <= '0;
      addr_out          <= '0;
      we                <= 1'b0;
      iData_RS232       <= '0;
      WriteEnable_RS232 <= 1'b0;
      read_addr_RS232   <= '0;
    end else begin
      we                <= 1'b0;
      WriteEnable_RS232 <= 1'b0;
      if (!enable) begin
        // Session cleared; RX pointer, info byte and last word are kept.
        state    <= IDLE;
        addr_out <= '0;
      end else begin
        if (we) addr_out <= addr_out + 1'b1;
        case (state)
          IDLE: begin
            if (rx_avail) begin
              byte_r          <= oData_RS232;
              read_addr_RS232 <= read_addr_RS232 + 1'b1;
              state           <= ECHO;
            end
          end
          ECHO: begin
            if (!oWrBuffer_full_RS232) begin
              iData_RS232       <= byte_r;
              WriteEnable_RS232 <= 1'b1;
              oInfobyte         <= byte_r;
              state             <= word_ready ? WRITE : IDLE;
            end
          end
          WRITE: begin
            dout  <= word;
            we    <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs232_programmer.sv
// Randomized bench for rs232_programmer against a byte-stream reference model.
module tb_rs232_programmer;

  logic        clk = 1'b0;
  logic        rst, enable, tx_full;
  logic [7:0]  info, idata, odata;
  logic [31:0] dout, addr_out;
  logic        we, we_rs;
  logic [2:0]  rd_ptr, rx_ptr;
  logic [7:0]  rx_mem [8];

  always #5 clk = ~clk;
  assign odata = rx_mem[rd_ptr];

  rs232_programmer dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .oInfobyte            (info),
    .dout                 (dout),
    .addr_out             (addr_out),
    .we                   (we),
    .iData_RS232          (idata),
    .WriteEnable_RS232    (we_rs),
    .oWrBuffer_full_RS232 (tx_full),
    .oData_RS232          (odata),
    .read_addr_RS232      (rd_ptr),
    .rx_addr_RS232        (rx_ptr)
  );

  int          n_chk = 0, n_fail = 0;
  int          echo_cnt = 0, wr_cnt = 0;
  logic [7:0]  q_echo[$];
  logic [31:0] q_wd[$], q_wa[$];
  logic [7:0]  pend[$];
  logic [31:0] m_addr = 0;
  logic        full_s, prev_we = 1'b0, prev_we_rs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at posedge+1, observe strobes, return at negedge.
  task automatic tick();
    logic [7:0]  e;
    logic [31:0] wd, wa;
    full_s = tx_full;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (we_rs) begin
        echo_cnt++;
        if (full_s) chk("echo_while_full", 1, 0);
        if (prev_we_rs) chk("echo_pulse_width", 1, 0);
        if (q_echo.size() == 0) chk("echo_unexpected", 1, 0);
        else begin
          e = q_echo.pop_front();
          chk("echo_data", 32'(idata), 32'(e));
          chk("infobyte", 32'(info), 32'(e));
        end
      end
      if (we) begin
        wr_cnt++;
        if (prev_we) chk("we_pulse_width", 1, 0);
        if (q_wd.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          wd = q_wd.pop_front();
          wa = q_wa.pop_front();
          chk("write_data", dout, wd);
          chk("write_addr", addr_out, wa);
        end
      end
    end
    prev_we    = we;
    prev_we_rs = we_rs;
    @(negedge clk);
  endtask

  // Enqueue a byte in the UART RX buffer and in the reference model.
  task automatic push(input logic [7:0] b);
    int         g = 0;
    logic [2:0] occ;
    occ = rx_ptr - rd_ptr;
    while (occ == 3'd7 && g < 500) begin
      tx_full = 1'b0;
      tick();
      g++;
      occ = rx_ptr - rd_ptr;
    end
    if (g >= 500) chk("push_timeout", 1, 0);
    rx_mem[rx_ptr] = b;
    rx_ptr = rx_ptr + 3'd1;
    q_echo.push_back(b);
    pend.push_back(b);
    if (pend.size() == 4) begin
      q_wd.push_back({pend[0], pend[1], pend[2], pend[3]});
      q_wa.push_back(m_addr);
      m_addr = m_addr + 1;
      pend.delete();
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((q_echo.size() != 0 || q_wd.size() != 0 || rd_ptr != rx_ptr) && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) chk("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    pend.delete();
    m_addr = 0;
    repeat (2) tick();
  endtask

  initial begin
    int         n, e0, w0;
    logic [2:0] p0;
    rst = 1'b1; enable = 1'b0; tx_full = 1'b0; rx_ptr = '0;
    for (int i = 0; i < 8; i++) rx_mem[i] = '0;
    repeat (3) tick();
    chk("rst_info", 32'(info), 0);
    chk("rst_dout", dout, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_idata", 32'(idata), 0);
    chk("rst_we_rs", 32'(we_rs), 0);
    chk("rst_rdptr", 32'(rd_ptr), 0);
    rst = 1'b0; enable = 1'b1;
    tick();

    // Single word with exact latencies.
    push(8'h12);
    tick();
    chk("rdptr_t1", 32'(rd_ptr), 1);
    chk("no_echo_t1", 32'(echo_cnt), 0);
    tick();
    chk("echo_t2", 32'(echo_cnt), 1);
    push(8'h34); push(8'h56);
    drain();
    push(8'h78);
    tick(); tick();
    chk("we_not_early", 32'(wr_cnt), 0);
    tick();
    chk("we_t3", 32'(wr_cnt), 1);
    tick();
    chk("sw_addr_after", addr_out, 1);
    drain();
    chk("sw_rdptr", 32'(rd_ptr), 4);
    chk("sw_info", 32'(info), 32'h78);

    // Wrap-around through the 8-entry buffer; addresses restart at 0.
    drop_enable();
    enable = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 12; i++) begin
      push(8'(i));
      if (i % 3 == 2) tick();
    end
    drain();
    chk("wrap_writes", 32'(wr_cnt - w0), 3);
    chk("wrap_rdptr", 32'(rd_ptr), 0);
    chk("wrap_addr", addr_out, 3);

    // TX back-pressure.
    p0 = rd_ptr; e0 = echo_cnt;
    tx_full = 1'b1;
    push(8'h5A);
    repeat (10) tick();
    chk("bp_rdptr_once", 32'(rd_ptr), 32'(p0 + 3'd1));
    chk("bp_no_echo", 32'(echo_cnt), 32'(e0));
    tx_full = 1'b0;
    n = 0;
    while (echo_cnt == e0 && n < 5) begin tick(); n++; end
    chk("bp_echo_latency", 32'(n >= 1 && n <= 2), 1);
    drain();

    // Enable drop mid-word discards the partial word.
    push(8'hAA); push(8'hBB);
    drain();
    drop_enable();
    enable = 1'b1;
    w0 = wr_cnt;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    drain();
    chk("drop_one_write", 32'(wr_cnt - w0), 1);
    chk("drop_addr", addr_out, 1);

    // Idle guard: disabled block leaves a waiting byte alone.
    drop_enable();
    p0 = rd_ptr; e0 = echo_cnt; w0 = wr_cnt;
    push(8'hC3);
    repeat (10) tick();
    chk("guard_rdptr", 32'(rd_ptr), 32'(p0));
    chk("guard_no_echo", 32'(echo_cnt), 32'(e0));
    chk("guard_no_write", 32'(wr_cnt), 32'(w0));
    enable = 1'b1;
    drain();
    chk("guard_consumed", 32'(echo_cnt), 32'(e0 + 1));

    // Randomized traffic with TX stalls and occasional session restarts.
    for (int i = 0; i < 400; i++) begin
      tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      tick();
      if (i % 130 == 129) begin
        tx_full = 1'b0;
        drain();
        drop_enable();
        enable = 1'b1;
      end
    end
    tx_full = 1'b0;
    drain();
    chk("rand_addr", addr_out, m_addr);
    chk("rand_rdptr", 32'(rd_ptr), 32'(rx_ptr));

    // Reset mid-word loses the partial word.
    push(8'hDE); push(8'hAD);
    drain();
    rst = 1'b1; rx_ptr = '0;
    pend.delete(); m_addr = 0;
    tick();
    chk("mrst_rdptr", 32'(rd_ptr), 0);
    chk("mrst_addr", addr_out, 0);
    chk("mrst_info", 32'(info), 0);
    chk("mrst_dout", dout, 0);
    rst = 1'b0;
    tick();
    w0 = wr_cnt;
    push(8'hCA); push(8'hFE); push(8'hF0); push(8'h0D);
    drain();
    chk("mrst_one_write", 32'(wr_cnt - w0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
